// File: rtl/m2_pingpong_buffer.sv
// Dual-bank ping-pong sample buffer for the M2 telemetry frame generator.
// Optional build macro: TEST_PATTERN_EN replaces source writes with a generated ramp.
module m2_pingpong_buffer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iSwitch,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iAddr,
  output logic [DATA_W-1:0] oData,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iWrValid,
  output logic              oWrReady,
  output logic              oWrBank,
  output logic              oBankFull,
  output logic              oUnderrun,
  output logic              oOverrun,
  output logic [15:0]       oDropCnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [0:0] StFill = 1'b0;
  localparam logic [0:0] StFull = 1'b1;

  logic [DATA_W-1:0] mem [2*Depth];

  logic              sw_q;
  logic              swap_edge;
  logic [0:0]        st_q;
  logic              wr_bank_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              underrun_q;
  logic              overrun_q;
  logic [15:0]       drop_cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] rd_data;
  logic              rd_bank;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              drop;

  assign rd_bank   = ~wr_bank_q;
  assign rd_data   = mem[{rd_bank, iAddr}];
  // The generator samples on the edge right after raising iRdEn, so no register here.
  assign oData     = iRdEn ? rd_data : hold_q;

  assign swap_edge = iSwitch ^ sw_q;
  assign oBankFull = (st_q == StFull);
  assign oWrReady  = ~oBankFull & ~swap_edge;
  assign oWrBank   = wr_bank_q;
  assign oUnderrun = underrun_q;
  assign oOverrun  = overrun_q;
  assign oDropCnt  = drop_cnt_q;

`ifdef TEST_PATTERN_EN
  localparam int unsigned CntW = DATA_W - ADDR_W;

  logic [CntW-1:0] swap_cnt_q;
  logic            unused_wr;

  assign unused_wr = ^{iWrData, iWrValid};
  assign wr_en     = oWrReady;
  assign wr_data   = {swap_cnt_q, wr_ptr_q};
  assign drop      = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_cnt_q <= '0;
    end else if (swap_edge) begin
      swap_cnt_q <= swap_cnt_q + 1'b1;
    end
  end
`else
  assign wr_en   = iWrValid & oWrReady;
  assign wr_data = iWrData;
  // A word offered during a swap is retried by the source, so it is not counted.
  assign drop    = iWrValid & oBankFull & ~swap_edge;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_q, wr_ptr_q}] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_q       <= 1'b0;
      st_q       <= StFill;
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      sw_q <= iSwitch;
      if (iRdEn) begin
        hold_q <= rd_data;
      end
      if (swap_edge) begin
        wr_bank_q <= ~wr_bank_q;
        wr_ptr_q  <= '0;
        st_q      <= StFill;
        if (st_q == StFill) begin
          underrun_q <= 1'b1;
        end
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (wr_ptr_q == {ADDR_W{1'b1}}) begin
          st_q <= StFull;
        end
      end
      if (drop) begin
        overrun_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_m2_pingpong_buffer.sv
// Scoreboard bench for m2_pingpong_buffer: read data checked by a negedge monitor
// against a queue of hand-computed expectations; status flags checked inline.
module tb_m2_pingpong_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        iSwitch;
  logic        iRdEn;
  logic [7:0]  iAddr;
  logic [11:0] oData;
  logic [11:0] iWrData;
  logic        iWrValid;
  logic        oWrReady;
  logic        oWrBank;
  logic        oBankFull;
  logic        oUnderrun;
  logic        oOverrun;
  logic [15:0] oDropCnt;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [11:0] exp_q [$];
  logic [11:0] mon_exp;

  m2_pingpong_buffer #(
    .ADDR_W(8),
    .DATA_W(12)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .iSwitch  (iSwitch),
    .iRdEn    (iRdEn),
    .iAddr    (iAddr),
    .oData    (oData),
    .iWrData  (iWrData),
    .iWrValid (iWrValid),
    .oWrReady (oWrReady),
    .oWrBank  (oWrBank),
    .oBankFull(oBankFull),
    .oUnderrun(oUnderrun),
    .oOverrun (oOverrun),
    .oDropCnt (oDropCnt)
  );

  always #20 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Read monitor: every cycle with iRdEn high must match the next queued word.
  always @(negedge clk) begin
    if (reset && iRdEn) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_data addr %0d: got %h, required nothing (queue empty)", iAddr, oData);
      end else begin
        mon_exp = exp_q.pop_front();
        if (oData !== mon_exp) begin
          n_fail++;
          $display("FAIL rd_data addr %0d: got %h, required %h", iAddr, oData, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [11:0] d);
    step();
    iWrValid = 1'b1;
    iWrData  = d;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [11:0] e);
    step();
    iWrValid = 1'b0;
    iRdEn    = 1'b1;
    iAddr    = a;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " oData"},     32'(oData),     32'h0);
    chk({tag, " oWrBank"},   32'(oWrBank),   32'h0);
    chk({tag, " oBankFull"}, 32'(oBankFull), 32'h0);
    chk({tag, " oWrReady"},  32'(oWrReady),  32'h1);
    chk({tag, " oUnderrun"}, 32'(oUnderrun), 32'h0);
    chk({tag, " oOverrun"},  32'(oOverrun),  32'h0);
    chk({tag, " oDropCnt"},  32'(oDropCnt),  32'h0);
  endtask

  initial begin
    reset    = 1'b0;
    iSwitch  = 1'b0;
    iRdEn    = 1'b0;
    iAddr    = '0;
    iWrData  = '0;
    iWrValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Fill bank 0 with 0x000..0x0FF.
    for (int i = 0; i < 256; i++) write_word(12'(i));
    step();
    iWrValid = 1'b0;
    @(negedge clk);
    chk("fill oBankFull", 32'(oBankFull), 32'h1);
    chk("fill oWrReady",  32'(oWrReady),  32'h0);
    chk("fill oWrBank",   32'(oWrBank),   32'h0);

    // Offer 5 words to the full bank; they must be dropped and counted.
    step();
    iWrValid = 1'b1;
    iWrData  = 12'hABC;
    repeat (5) step();
    iWrValid = 1'b0;
    @(negedge clk);
    chk("overrun oOverrun", 32'(oOverrun), 32'h1);
    chk("overrun oDropCnt", 32'(oDropCnt), 32'd5);

    // Swap to bank 1 (bank 0 was full: no underrun), then read bank 0 back.
    step();
    iSwitch = 1'b1;
    @(negedge clk);
    chk("swap1 oWrReady", 32'(oWrReady), 32'h0);
    step();
    chk("swap1 oWrBank",   32'(oWrBank),   32'h1);
    chk("swap1 oUnderrun", 32'(oUnderrun), 32'h0);
    for (int a = 0; a < 256; a++) do_read(8'(a), 12'(a));
    step();
    iRdEn = 1'b0;
    iAddr = 8'd3;
    @(negedge clk);
    chk("hold oData", 32'(oData), 32'h0FF);

    // Partial fill of bank 1, then swap: underrun.
    for (int i = 0; i < 100; i++) write_word(12'h500 + 12'(i));
    step();
    iWrValid = 1'b0;
    iSwitch  = 1'b0;
    step();
    chk("swap2 oUnderrun", 32'(oUnderrun), 32'h1);
    chk("swap2 oWrBank",   32'(oWrBank),   32'h0);
    for (int a = 0; a < 100; a++) do_read(8'(a), 12'h500 + 12'(a));
    step();
    iRdEn = 1'b0;

    // Three words into bank 0 from pointer 0; swap with a word offered in the swap cycle.
    for (int i = 0; i < 3; i++) write_word(12'h900 + 12'(i));
    step();
    iSwitch  = 1'b1;
    iWrValid = 1'b1;
    iWrData  = 12'h7FF;
    iRdEn    = 1'b1;
    iAddr    = 8'd0;
    exp_q.push_back(12'h500);
    @(negedge clk);
    chk("swap3 oWrReady", 32'(oWrReady), 32'h0);
    step();
    iWrValid = 1'b0;
    iRdEn    = 1'b0;
    chk("swap3 oDropCnt", 32'(oDropCnt), 32'd5);
    chk("swap3 oWrBank",  32'(oWrBank),  32'h1);
    for (int a = 0; a < 3; a++) do_read(8'(a), 12'h900 + 12'(a));
    for (int a = 3; a < 8; a++) do_read(8'(a), 12'(a));
    step();
    iRdEn = 1'b0;

    // Reset in the middle of filling bank 1 (wrPtr = 37).
    for (int i = 0; i < 37; i++) write_word(12'hA00 + 12'(i));
    @(posedge clk);
    #3;
    reset    = 1'b0;
    iSwitch  = 1'b0;
    iWrValid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    chk("postreset oWrBank",  32'(oWrBank),  32'h0);
    chk("postreset oWrReady", 32'(oWrReady), 32'h1);
    do_read(8'd0,  12'hA00);
    do_read(8'd36, 12'hA24);
    step();
    iRdEn = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued reads left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/m2_pingpong_buffer.md
# m2_pingpong_buffer

Dual-bank (ping-pong) sample buffer feeding the M2 telemetry frame generator. An upstream sample source writes 12-bit words sequentially into the inactive bank. The frame generator reads the active bank by address. Banks swap on every toggle of the generator's bank-switch line, and overrun/underrun conditions are reported to the system.

## Interface
Parameters:
- ADDR_W, 8, bank address width; bank depth = 2^ADDR_W words
- DATA_W, 12, word width

Ports:
- clk  in  1  system clock (25.165824 MHz)
- reset  in  1  asynchronous, active-low
- iSwitch  in  1  bank-switch level from frame generator; every edge swaps banks
- iRdEn  in  1  read strobe from frame generator
- iAddr  in  ADDR_W  read address into active bank
- oData  out  DATA_W  read data to frame generator
- iWrData  in  DATA_W  sample from upstream source
- iWrValid  in  1  iWrData valid
- oWrReady  out  1  buffer accepts a write this cycle
- oWrBank  out  1  index of bank currently being written
- oBankFull  out  1  write bank holds 2^ADDR_W words
- oUnderrun  out  1  sticky: a swap occurred before the write bank was full
- oOverrun  out  1  sticky: a valid word was presented while full
- oDropCnt  out  16  count of dropped words, saturating

## Operation
Storage:
- Two banks of 2^ADDR_W × DATA_W. Memory contents are not reset.
- Read bank rdBank = ~oWrBank.

Read path:
- While iRdEn=1, oData = mem[rdBank][iAddr] combinationally (asynchronous read).
- The same value is also captured into a hold register each cycle.
- While iRdEn=0, oData = hold register.
- The generator samples oData on the first clk edge after it raises iRdEn together with a new iAddr. The combinational path therefore must not be registered.

Swap detection:
- swReg <= iSwitch every cycle.
- swapEdge = iSwitch ^ swReg (combinational).

On a cycle with swapEdge=1:
- oWrBank <= ~oWrBank; wrPtr <= 0; oBankFull <= 0.
- If oBankFull=0 before the swap, oUnderrun <= 1.

Write path:
- oWrReady = ~oBankFull & ~swapEdge.
- Accept when iWrValid & oWrReady: mem[oWrBank][wrPtr] <= iWrData; wrPtr <= wrPtr+1.
- Writing address 2^ADDR_W−1 sets oBankFull <= 1. wrPtr then wraps to 0 but is unused until the next swap.
- iWrValid=1 while oBankFull=1: the word is dropped, oOverrun <= 1, and oDropCnt increments, saturating at 0xFFFF.
- iWrValid=1 during a swapEdge cycle: the word is dropped but not counted. The source retries, since ready was low.

Write state machine:
- FILL (oBankFull=0) → FULL on the last write.
- FULL → FILL on swapEdge.
- A swapEdge in FILL → FILL with wrPtr=0 (underrun).

Sticky flags and counters:
- oUnderrun, oOverrun and oDropCnt clear only on reset.

## Timing
Reset values:
- oData=0, hold=0, oWrBank=0, wrPtr=0, oBankFull=0, oUnderrun=0, oOverrun=0, oDropCnt=0.
- swReg is loaded from iSwitch on the first clk after reset release, so no spurious swap occurs. Internally, reset loads swReg=0; the frame generator's switch line also resets to 0.

Latencies:
- Read: 0 cycles, address to oData, while iRdEn=1.
- Write: data is visible to the read side only after the next swap.
- Swap: rdBank changes on the clk edge following the iSwitch transition. A read issued in that same cycle still sees the old bank.
- oBankFull rises on the edge that commits the last word. oWrReady falls in the same cycle.

Reset mid-operation:
- All state returns to reset values immediately (asynchronous).
- Memory keeps stale data.

## Configuration
TEST_PATTERN_EN:
- Defined:
  - The write path ignores iWrData and iWrValid.
  - One word is written every cycle while oWrReady=1, with data = {swapCnt[DATA_W−ADDR_W−1:0], wrPtr}. swapCnt is an internal counter incremented on each swapEdge and reset to 0.
  - oOverrun and oDropCnt stay 0.
- Undefined: normal source-driven writes as described above.

## Test plan
1. Reset, then write 256 words 0x000..0x0FF with iWrValid held high.
   - oBankFull=1 after the 256th write.
   - oWrReady=0.
   - oWrBank=0.
2. Toggle iSwitch 0→1, then read addresses 0..255 with iRdEn=1.
   - oData equals the address on each read.
   - oWrBank=1.
   - oUnderrun=0.
3. With the write bank full, hold iWrValid for 5 cycles.
   - oOverrun=1.
   - oDropCnt=5.
   - Bank contents unchanged.
4. Write 100 words, then toggle iSwitch.
   - oUnderrun=1.
   - wrPtr restarts at 0 in the other bank.
   - Addresses 0..99 of the new read bank hold the written data.
5. Assert iWrValid in the swapEdge cycle.
   - oWrReady=0 in that cycle.
   - Word not written.
   - oDropCnt unchanged.
6. Assert reset mid-fill (wrPtr=37).
   - All outputs return to reset values.
   - With TEST_PATTERN_EN defined, after release bank 0 holds 0x000..0x0FF within 256 cycles.
